pipe_hazard_ctrl: RTL

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl_if.sv | 36 +++
 rtl/pipe_hazard_ctrl.sv | 126 ++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// The datapath side is the master; the hazard controller is the slave.
interface pipe_hazard_ctrl_if;
  // Hazard sources from the pipeline
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rt;
  logic        ex_memread;
  logic [4:0]  ex_rt;
  logic        redirect;
  logic        mem_req;
  logic        dmem_ready;
  logic        cnt_clr;
  // Pipeline controls and status back to the datapath
  logic        pc_en;
  logic        ifid_en;
  logic        ifid_flush;
  logic        idex_en;
  logic        idex_flush;
  logic        exmem_en;
  logic [1:0]  state;
  logic [15:0] stall_cycles;
  logic [7:0]  flush_events;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_memread, ex_rt, redirect, mem_req, dmem_ready, cnt_clr,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, state, stall_cycles,
           flush_events
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_memread, ex_rt, redirect, mem_req, dmem_ready, cnt_clr,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, state, stall_cycles,
           flush_events
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch/jump flushes and data-memory
// wait stalls for a 5-stage pipeline, plus saturating stall/flush performance counters.
// All pipeline controls are combinational from the registered state and current inputs.
module pipe_hazard_ctrl (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave io_hz
);

  localparam logic [1:0] StRun     = 2'd0;
  localparam logic [1:0] StLdStall = 2'd1;
  localparam logic [1:0] StFlush   = 2'd2;
  localparam logic [1:0] StMemWait = 2'd3;

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [15:0] r_stall_cycles;
  logic [7:0]  r_flush_events;

  logic w_mem_wait;
  logic w_load_use;
  logic w_redirect_acc;
  logic w_pc_en;
  logic w_ifid_en;
  logic w_ifid_flush;
  logic w_idex_en;
  logic w_idex_flush;
  logic w_exmem_en;

  // Raw hazard conditions, before state-dependent suppression
  always_comb begin
    w_mem_wait = io_hz.mem_req & ~io_hz.dmem_ready;
    w_load_use = io_hz.ex_memread && (io_hz.ex_rt != 5'd0) &&
                 ((io_hz.ex_rt == io_hz.id_rs) ||
                  (io_hz.id_uses_rt && (io_hz.ex_rt == io_hz.id_rt)));
  end

  // Priority decode of pipeline controls and next state: rst > mem wait > redirect > load-use
  always_comb begin
    w_pc_en        = 1'b1;
    w_ifid_en      = 1'b1;
    w_ifid_flush   = 1'b0;
    w_idex_en      = 1'b1;
    w_idex_flush   = 1'b0;
    w_exmem_en     = 1'b1;
    w_redirect_acc = 1'b0;
    w_state_nxt    = StRun;
    if (rst) begin
      // Hold the PC and push bubbles through the front of the pipeline
      w_pc_en      = 1'b0;
      w_ifid_flush = 1'b1;
      w_idex_flush = 1'b1;
    end else if (w_mem_wait) begin
      w_pc_en     = 1'b0;
      w_ifid_en   = 1'b0;
      w_idex_en   = 1'b0;
      w_exmem_en  = 1'b0;
      w_state_nxt = StMemWait;
    end else begin
      unique case (r_state)
        StFlush: begin
          // Squash the wrong-path fetch; a second redirect here is stale and ignored
          w_ifid_flush = 1'b1;
        end
        StLdStall: begin
          // Bubble already inserted, so only a redirect can override the release cycle
          if (io_hz.redirect) begin
            w_ifid_flush   = 1'b1;
            w_idex_flush   = 1'b1;
            w_redirect_acc = 1'b1;
            w_state_nxt    = StFlush;
          end
        end
        StRun, StMemWait: begin
          if (io_hz.redirect) begin
            w_ifid_flush   = 1'b1;
            w_idex_flush   = 1'b1;
            w_redirect_acc = 1'b1;
            w_state_nxt    = StFlush;
          end else if (w_load_use) begin
            w_pc_en      = 1'b0;
            w_ifid_en    = 1'b0;
            w_idex_flush = 1'b1;
            w_state_nxt  = StLdStall;
          end
        end
        default: w_state_nxt = StRun;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StRun;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Saturating performance counters; clear wins over increment
  always_ff @(posedge clk) begin
    if (rst || io_hz.cnt_clr) begin
      r_stall_cycles <= 16'd0;
      r_flush_events <= 8'd0;
    end else begin
      if (!w_pc_en && (r_stall_cycles != 16'hFFFF)) begin
        r_stall_cycles <= r_stall_cycles + 16'd1;
      end
      if (w_redirect_acc && (r_flush_events != 8'hFF)) begin
        r_flush_events <= r_flush_events + 8'd1;
      end
    end
  end

  assign io_hz.pc_en        = w_pc_en;
  assign io_hz.ifid_en      = w_ifid_en;
  assign io_hz.ifid_flush   = w_ifid_flush;
  assign io_hz.idex_en      = w_idex_en;
  assign io_hz.idex_flush   = w_idex_flush;
  assign io_hz.exmem_en     = w_exmem_en;
  assign io_hz.state        = r_state;
  assign io_hz.stall_cycles = r_stall_cycles;
  assign io_hz.flush_events = r_flush_events;

endmodule
